// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag unit: flag-vector layout, flag-instruction
// and branch-condition encodings, and the condition evaluator.
package flag_unit_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_I = 3;

  typedef enum logic [2:0] {
    OP_NONE   = 3'b000,
    OP_SETC   = 3'b001,
    OP_CLRC   = 3'b010,
    OP_SETI   = 3'b011,
    OP_CLRI   = 3'b100,
    OP_CLRERR = 3'b101
  } flag_op_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_C      = 3'b011,
    COND_NC     = 3'b100,
    COND_N      = 3'b101,
    COND_NN     = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  function automatic logic eval_cond(input logic [2:0] sel, input flags_t f);
    logic res;
    res = 1'b0;
    case (sel)
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = f[FLAG_Z];
      COND_NZ:     res = ~f[FLAG_Z];
      COND_C:      res = f[FLAG_C];
      COND_NC:     res = ~f[FLAG_C];
      COND_N:      res = f[FLAG_N];
      COND_NN:     res = ~f[FLAG_N];
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Small LIFO for flag sets saved across interrupts. Callers must not push
// when full or pop when empty; such requests are simply ignored here.
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);

  // Storage is sized to the full index range so the occupancy counter can
  // address it directly; entries at or above DEPTH are never written.
  logic [WIDTH-1:0] mem [1 << DW];
  logic [DW-1:0]    depth_reg;
  logic [DW-1:0]    top_idx;

  assign top_idx = depth_reg - DW'(1);
  assign dout    = mem[top_idx];
  assign full    = (depth_reg == DW'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign depth   = depth_reg;

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[depth_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + DW'(1);
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - DW'(1);
    end
  end

endmodule

// File: rtl/flag_unit.sv
// CPU status-flag register with interrupt save/restore stack and the
// branch-condition evaluator feeding the control unit.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alu_c,
  input  logic                               alu_z,
  input  logic                               alu_n,
  input  logic                               flag_we,
  input  logic [2:0]                         flag_op,
  input  logic                               irq_entry,
  input  logic                               irq_return,
  input  logic [2:0]                         cond,
  output logic                               c_flag,
  output logic                               z_flag,
  output logic                               n_flag,
  output logic                               i_flag,
  output logic                               cond_true,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_err
);

  flags_t flags_reg, flags_next, staged, stack_top;
  logic   err_reg, err_next;
  logic   full, empty;
  logic   do_push, do_pop, overflow, underflow;

  assign do_push   = irq_entry & ~full;
  assign overflow  = irq_entry & full;
  assign do_pop    = irq_return & ~irq_entry & ~empty;
  assign underflow = irq_return & ~irq_entry & empty;

  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (4)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (staged),
    .dout  (stack_top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Flags as the retiring instruction would leave them; flag_op is applied
  // after the ALU write so it wins on C.
  always_comb begin
    staged = flags_reg;
    if (flag_we) begin
      staged[FLAG_C] = alu_c;
      staged[FLAG_Z] = alu_z;
      staged[FLAG_N] = alu_n;
    end
    case (flag_op)
      OP_SETC: staged[FLAG_C] = 1'b1;
      OP_CLRC: staged[FLAG_C] = 1'b0;
      OP_SETI: staged[FLAG_I] = 1'b1;
      OP_CLRI: staged[FLAG_I] = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    flags_next = staged;
    if (irq_entry) begin
      flags_next[FLAG_I] = 1'b0;
    end else if (do_pop) begin
      flags_next = stack_top;
    end
  end

  // A stack fault in the same cycle takes priority over CLRERR.
  always_comb begin
    err_next = err_reg;
    if (overflow || underflow) begin
      err_next = 1'b1;
    end else if (flag_op == OP_CLRERR) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      err_reg   <= err_next;
    end
  end

  assign c_flag    = flags_reg[FLAG_C];
  assign z_flag    = flags_reg[FLAG_Z];
  assign n_flag    = flags_reg[FLAG_N];
  assign i_flag    = flags_reg[FLAG_I];
  assign stack_err = err_reg;
  assign cond_true = eval_cond(cond, flags_reg);

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: a queue-based reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_flag_unit;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_c, alu_z, alu_n, flag_we;
  logic [2:0] flag_op, cond;
  logic       irq_entry, irq_return;
  logic       c_flag, z_flag, n_flag, i_flag, cond_true, stack_err;
  logic [2:0] depth;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  flag_unit #(.STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .flag_we    (flag_we),
    .flag_op    (flag_op),
    .irq_entry  (irq_entry),
    .irq_return (irq_return),
    .cond       (cond),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .n_flag     (n_flag),
    .i_flag     (i_flag),
    .cond_true  (cond_true),
    .depth      (depth),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  // Reference model: flags as {I,N,Z,C}, saved sets in a queue.
  logic [3:0] m_f = 4'b0;
  logic       m_err = 1'b0;
  logic [3:0] stk [$];
  logic [3:0] s;
  logic       clr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_f = 4'b0;
      m_err = 1'b0;
      stk.delete();
    end else begin
      s = m_f;
      if (flag_we) s[2:0] = {alu_n, alu_z, alu_c};
      if (flag_op == 3'd1) s[0] = 1'b1;
      if (flag_op == 3'd2) s[0] = 1'b0;
      if (flag_op == 3'd3) s[3] = 1'b1;
      if (flag_op == 3'd4) s[3] = 1'b0;
      clr = (flag_op == 3'd5);
      if (irq_entry) begin
        if (stk.size() < SD) begin
          stk.push_back(s);
          if (clr) m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_f = s & 4'b0111;
      end else if (irq_return) begin
        if (stk.size() > 0) begin
          m_f = stk.pop_back();
          if (clr) m_err = 1'b0;
        end else begin
          m_f = s;
          m_err = 1'b1;
        end
      end else begin
        m_f = s;
        if (clr) m_err = 1'b0;
      end
    end
  end

  function automatic logic m_cond(input logic [2:0] c, input logic [3:0] f);
    logic r;
    case (c)
      3'd0: r = 1'b1;
      3'd1: r = f[1];
      3'd2: r = !f[1];
      3'd3: r = f[0];
      3'd4: r = !f[0];
      3'd5: r = f[2];
      3'd6: r = !f[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
    chk(name, int'({i_flag, n_flag, z_flag, c_flag}), int'(exp));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_flags", int'({i_flag, n_flag, z_flag, c_flag}), int'(m_f));
      chk("model_cond", int'(cond_true), int'(m_cond(cond, m_f)));
      chk("model_depth", int'(depth), stk.size());
      chk("model_err", int'(stack_err), int'(m_err));
    end
  end

  // Drive one instruction cycle; cnz is {n,z,c}. Returns at negedge + 1.
  task automatic step(input logic we, input logic [2:0] cnz, input logic [2:0] op,
                      input logic ent, input logic ret);
    flag_we = we;
    {alu_n, alu_z, alu_c} = cnz;
    flag_op = op;
    irq_entry = ent;
    irq_return = ret;
    @(negedge clk);
    #1;
    $display("step we=%0b alu=%03b op=%0d ent=%0b ret=%0b -> INZC=%04b depth=%0d err=%0b",
             we, cnz, op, ent, ret, {i_flag, n_flag, z_flag, c_flag}, depth, stack_err);
  endtask

  task automatic check_cond(input logic [2:0] c, input logic exp);
    cond = c;
    #1;
    chk($sformatf("cond_%0d", c), int'(cond_true), int'(exp));
  endtask

  logic [3:0] pop_exp [4] = '{4'b0011, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    rst = 1'b0;
    flag_we = 0; alu_c = 0; alu_z = 0; alu_n = 0;
    flag_op = 3'd0; irq_entry = 0; irq_return = 0; cond = 3'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    chk_flags("reset_flags", 4'b0000);
    chk("reset_depth", int'(depth), 0);
    chk("reset_err", int'(stack_err), 0);
    rst = 1'b1;

    // ALU write, then branch conditions on the result
    step(1, 3'b101, 3'd0, 0, 0);
    chk_flags("we_101", 4'b0101);
    check_cond(3'd3, 1'b1);
    check_cond(3'd2, 1'b1);
    check_cond(3'd7, 1'b0);
    check_cond(3'd1, 1'b0);

    // SETC overrides ALU carry
    step(1, 3'b000, 3'd1, 0, 0);
    chk("setc_over_we", int'(c_flag), 1);

    // Basic save/restore
    step(0, 3'b000, 3'd3, 0, 0);
    step(1, 3'b011, 3'd0, 0, 0);
    step(0, 3'b000, 3'd0, 1, 0);
    chk("entry_i", int'(i_flag), 0);
    chk("entry_depth", int'(depth), 1);
    step(1, 3'b000, 3'd0, 0, 0);
    step(0, 3'b000, 3'd0, 0, 1);
    chk_flags("return_flags", 4'b1011);
    chk("return_depth", int'(depth), 0);

    // Push captures the same-cycle ALU write
    step(1, 3'b000, 3'd0, 0, 0);
    step(1, 3'b010, 3'd0, 1, 0);
    step(1, 3'b000, 3'd0, 0, 0);
    chk("z_cleared", int'(z_flag), 0);
    step(0, 3'b000, 3'd0, 0, 1);
    chk("z_restored", int'(z_flag), 1);

    // Overflow on the fifth entry, then LIFO restore and underflow
    for (int k = 0; k < 5; k++) begin
      step(1, k[2:0], 3'd0, 1, 0);
    end
    chk("ovf_depth", int'(depth), 4);
    chk("ovf_err", int'(stack_err), 1);
    chk_flags("ovf_flags", 4'b0100);
    for (int k = 0; k < 4; k++) begin
      step(0, 3'b000, 3'd0, 0, 1);
      chk_flags($sformatf("pop_%0d", k), pop_exp[k]);
    end
    step(0, 3'b000, 3'd0, 0, 1);
    chk("udf_err", int'(stack_err), 1);
    chk_flags("udf_flags", 4'b1000);
    step(0, 3'b000, 3'd5, 0, 0);
    chk("clrerr", int'(stack_err), 0);

    // Entry and return together: entry wins
    step(0, 3'b000, 3'd0, 1, 1);
    chk("both_depth", int'(depth), 1);
    chk("both_err", int'(stack_err), 0);

    // Asynchronous reset mid-interrupt
    step(1, 3'b111, 3'd0, 1, 0);
    chk("pre_rst_depth", int'(depth), 2);
    cond = 3'd3;
    #1 rst = 1'b0;
    #1;
    chk_flags("async_rst_flags", 4'b0000);
    chk("async_rst_depth", int'(depth), 0);
    chk("async_rst_err", int'(stack_err), 0);
    chk("async_rst_cond", int'(cond_true), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    step(0, 3'b000, 3'd0, 0, 1);
    chk("post_rst_udf", int'(stack_err), 1);
    chk("post_rst_depth", int'(depth), 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

CPU status-flag register and branch-condition evaluator; the consumer side of the ALU's carry/zero/negative outputs. Latches ALU flags on flag-writing instructions and executes explicit flag instructions. Saves and restores the flag set on interrupt entry and return through a small LIFO. Drives the ALU carry-in and the branch-taken decision to the control unit.

## Interface
- STACK_DEPTH, 4, number of flag sets the interrupt shadow stack holds (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alu_c  in  1  ALU carry out
- alu_z  in  1  ALU zero out
- alu_n  in  1  ALU negative out
- flag_we  in  1  latch alu_c/z/n into C/Z/N this cycle
- flag_op  in  3  000 none, 001 SETC, 010 CLRC, 011 SETI, 100 CLRI, 101 CLRERR, 110/111 none
- irq_entry  in  1  interrupt accepted: push flags, clear I
- irq_return  in  1  return from interrupt: pop flags
- cond  in  3  branch condition: 000 always, 001 Z, 010 NZ, 011 C, 100 NC, 101 N, 110 NN, 111 never
- c_flag, z_flag, n_flag, i_flag  out  1 each  registered flags; c_flag also drives ALU cin
- cond_true  out  1  selected condition evaluated on registered flags
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy
- stack_err  out  1  sticky overflow/underflow indicator

## Operation
- Reset: C=Z=N=I=0, depth=0, stack_err=0, stack contents don't-care.
- Next-state ("staged") flags per cycle, in order:
  - start from registered {I,N,Z,C};
  - flag_we=1: C,Z,N ← alu_c, alu_z, alu_n;
  - then flag_op applied: SETC C←1, CLRC C←0, SETI I←1, CLRI I←0, CLRERR stack_err←0. flag_op overrides flag_we on C when both hit it.
- irq_entry=1: push staged {I,N,Z,C} (post-update values of the instruction retiring this cycle); registered flags ← staged with I forced 0; depth+1.
- irq_return=1 (irq_entry=0): registered {I,N,Z,C} ← top of stack; depth−1; flag_we and flag_op (except CLRERR) ignored this cycle.
- irq_entry and irq_return both 1: entry wins, return ignored, no error.
- Overflow: irq_entry with depth==STACK_DEPTH → push dropped, depth unchanged, I still cleared, flags still staged, stack_err←1.
- Underflow: irq_return with depth==0 → flags unchanged by pop, flag_we/flag_op applied normally, stack_err←1.
- stack_err set has priority over CLRERR in the same cycle.
- CMP flag meanings (C=A<B, Z=A==B, N=A>B) arrive pre-encoded from the ALU; this block treats all modes uniformly.

## Timing
- All flag, depth and error updates on rising clk; single-cycle, no stall.
- cond_true, c_flag: purely combinational from registered state. An instruction writing flags in cycle k is visible to a branch or ADC/SBB in cycle k+1.
- Back-to-back irq_entry each cycle permitted. Pop immediately after push returns the just-pushed set.
- Reset asserted mid-interrupt: stack cleared (depth 0), flags zeroed immediately, asynchronously.

## Structure
- Shared package: flag_op encodings, cond encodings, flag-vector bit positions (C=0, Z=1, N=2, I=3), 4-bit flag vector typedef.
- Sub-module flag_stack: parameterised LIFO of 4-bit entries (push, pop, data in/out, depth, full, empty). No error logic inside it.
- Top: staging logic, priority mux, condition mux, sticky error.

## Test plan
- Reset then flag_we with alu {c,z,n}={1,0,1} → next cycle c_flag=1, z_flag=0, n_flag=1; cond=011 → cond_true=1, cond=010 → 1, cond=111 → 0.
- flag_we with alu_c=0 and flag_op=SETC same cycle → c_flag=1.
- SETI; set C=1,Z=1; irq_entry alone → i_flag=0, depth=1. Then flag_we all 0, then irq_return → {I,N,Z,C}={1,0,1,1}, depth=0.
- irq_entry same cycle as flag_we alu_z=1 with Z previously 0 → pop later restores Z=1.
- STACK_DEPTH=4: five irq_entry → depth=4, stack_err=1. Four irq_return restore in LIFO order. A fifth → stack_err stays 1, flags unchanged. CLRERR → stack_err=0.
- Assert rst mid-sequence with depth=2 → all outputs 0 immediately, before the next clk edge. Release and irq_return → underflow, stack_err=1.
